pc_seq: RTL

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_seq.sv | 93 +++++++++
 1 files changed

// File: rtl/pc_seq.sv
// Program counter sequencer: reset vector, sequential advance, stall, aligned redirect.
// Optional exception entry/return with saved EPC when PC_EXC_EN is defined.
module pc_seq #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       STEP      = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [31:0]       EXC_VEC   = 32'h0000_0180
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redir_i,
  input  logic [ADDR_W-1:0] redir_addr_i,
  input  logic              exc_i,
  input  logic              eret_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] epc_o
);

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } state_t;

  localparam logic [ADDR_W-1:0] STEP_V   = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(STEP - 1);

  state_t state;

`ifdef PC_EXC_EN
  localparam logic [ADDR_W-1:0] EXC_V = ADDR_W'(EXC_VEC);

  logic [ADDR_W-1:0] epc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q <= '0;
    end else if (state == ST_RUN && exc_i) begin
      epc_q <= pc_o;
    end
  end

  assign epc_o = epc_q;
`else
  logic unused_exc;
  assign unused_exc = ^{exc_i, eret_i, EXC_VEC};
  assign epc_o      = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BOOT;
      pc_o       <= RESET_VEC;
      pc_valid_o <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      case (state)
        // First edge out of reset presents RESET_VEC as valid without advancing.
        ST_BOOT: begin
          state      <= ST_RUN;
          pc_o       <= RESET_VEC;
          pc_valid_o <= 1'b1;
          misalign_o <= 1'b0;
        end
        ST_RUN: begin
          misalign_o <= 1'b0;
`ifdef PC_EXC_EN
          if (exc_i) begin
            pc_o <= EXC_V;
          end else if (eret_i) begin
            pc_o <= epc_q;
          end else
`endif
          if (redir_i) begin
            pc_o       <= redir_addr_i & ~LOW_MASK;
            misalign_o <= |(redir_addr_i & LOW_MASK);
          end else if (!stall_i) begin
            pc_o <= pc_o + STEP_V;
          end
        end
        default: begin
          state      <= ST_BOOT;
          pc_o       <= RESET_VEC;
          pc_valid_o <= 1'b0;
          misalign_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
